// File: rtl/heichips25_sig_capture.sv
// Signature capture for the tiny wrapper outputs: waits for a masked trigger on
// uo_out, then folds win_len sample words into a 16-bit MISR (poly 0x1021).
module heichips25_sig_capture #(
    parameter int unsigned WIN_W = 16,
    parameter logic [15:0] SEED  = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       uo_out,
    input  logic [7:0]       uio_out,
    input  logic [7:0]       uio_oe,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic [7:0]       trig_mask,
    input  logic [7:0]       trig_val,
    output logic             busy,
    output logic             done,
    output logic [15:0]      signature,
    output logic [WIN_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       val_q, val_d;
    logic [15:0]      sig_q, sig_d;
    logic [WIN_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [15:0] sample;
    logic [15:0] misr_next;
    logic        match;

    always_comb begin
        sample    = {uio_out & uio_oe, uo_out};
        misr_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ sample;
        match     = ((uo_out & mask_q) == (val_q & mask_q));

        state_d = state_q;
        len_d   = len_q;
        mask_d  = mask_q;
        val_d   = val_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;

        if (abort) begin
            state_d = S_IDLE;
            sig_d   = SEED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_d   = win_len;
                        mask_d  = trig_mask;
                        val_d   = trig_val;
                        sig_d   = SEED;
                        cnt_d   = '0;
                        state_d = (win_len == '0) ? S_DONE : S_ARM;
                    end
                end
                S_ARM: begin
                    if (match) begin
                        sig_d   = misr_next;
                        cnt_d   = WIN_W'(1);
                        state_d = (len_q == WIN_W'(1)) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    // Full window already folded: leave without taking another sample.
                    if (cnt_q == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        sig_d = misr_next;
                        cnt_d = cnt_q + WIN_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            mask_q  <= '0;
            val_q   <= '0;
            sig_q   <= SEED;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mask_q  <= mask_d;
            val_q   <= val_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign signature  = sig_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_heichips25_sig_capture.sv
// Randomized and directed bench for heichips25_sig_capture; each run's timeline
// and signature are predicted from the trigger index and the folded sample list.
module tb_heichips25_sig_capture;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   uo_out, uio_out, uio_oe;
    logic         start, abort;
    logic [W-1:0] win_len;
    logic [7:0]   trig_mask, trig_val;
    logic         busy, done;
    logic [15:0]  signature;
    logic [W-1:0] sample_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    heichips25_sig_capture #(.WIN_W(W), .SEED(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe),
        .start(start), .abort(abort), .win_len(win_len), .trig_mask(trig_mask),
        .trig_val(trig_val), .busy(busy), .done(done), .signature(signature),
        .sample_cnt(sample_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
        int unsigned v;
        v = (int'(s) * 2) % 65536;
        if (int'(s) >= 32768) v = v ^ 32'h1021;
        return 16'(v) ^ d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic b, input logic dn,
                              input logic [15:0] sig, input int cnt);
        check_eq({tag, "_busy"}, 32'(busy), 32'(b));
        check_eq({tag, "_done"}, 32'(done), 32'(dn));
        check_eq({tag, "_sig"}, 32'(signature), 32'(sig));
        check_eq({tag, "_cnt"}, 32'(sample_cnt), 32'(cnt));
    endtask

    // mode 0 random, 1 uio_oe=0 with toggling uio_out, 2 uio_out=0, 3 all zero.
    // sel 0 forces a trigger miss, 1 forces a hit, 2 leaves uo_out free.
    task automatic drive_data(input int mode, input int j, input logic [7:0] mask,
                              input logic [7:0] val, input int sel, output logic [15:0] d);
        logic [7:0] u;
        case (mode)
            0: begin u = 8'($urandom); uio_out = 8'($urandom); uio_oe = 8'($urandom); end
            1: begin u = 8'(j * 29 + 3); uio_out = (j % 2 == 1) ? 8'hAA : 8'h55; uio_oe = 8'h00; end
            2: begin u = 8'(j * 29 + 3); uio_out = 8'h00; uio_oe = 8'($urandom); end
            default: begin u = 8'h00; uio_out = 8'h00; uio_oe = 8'h00; end
        endcase
        if (sel == 0) u = (u & ~mask) | (~val & mask);
        if (sel == 1) u = (u & ~mask) | (val & mask);
        uo_out = u;
        d = {uio_out & uio_oe, uo_out};
    endtask

    task automatic do_run(input logic [15:0] len, input logic [7:0] mask, input logic [7:0] val,
                          input int pre, input int mode, input bit poke,
                          output logic [15:0] sig_res);
        logic [15:0] es;
        logic [15:0] d;
        int          n;
        n = int'(len);
        win_len = len; trig_mask = mask; trig_val = val; start = 1'b1;
        drive_data(mode, 0, mask, val, 2, d);
        tick;
        start = 1'b0;
        win_len = W'($urandom); trig_mask = 8'($urandom); trig_val = 8'($urandom);
        es = 16'hFFFF;
        if (n == 0) begin
            check_outs("zero", 1'b0, 1'b1, es, 0);
        end else begin
            check_outs("start", 1'b1, 1'b0, es, 0);
            for (int i = 0; i < pre; i++) begin
                drive_data(mode, i + 1, mask, val, 0, d);
                tick;
                check_outs("arm", 1'b1, 1'b0, es, 0);
            end
            drive_data(mode, pre + 1, mask, val, 1, d);
            es = misr(es, d);
            tick;
            check_outs("match", n != 1, n == 1, es, 1);
            for (int j = 2; j <= n; j++) begin
                drive_data(mode, pre + j, mask, val, 2, d);
                if (poke && j == 2) begin
                    start = 1'b1; win_len = W'(1); trig_mask = 8'h00;
                end
                es = misr(es, d);
                tick;
                start = 1'b0;
                check_outs("cap", 1'b1, 1'b0, es, j);
            end
            if (n != 1) begin
                drive_data(mode, pre + n + 1, mask, val, 2, d);
                tick;
                check_outs("done", 1'b0, 1'b1, es, n);
            end
        end
        for (int h = 0; h < 2; h++) begin
            drive_data(0, 0, mask, val, 2, d);
            tick;
            check_outs("hold", 1'b0, 1'b1, es, n);
        end
        sig_res = es;
    endtask

    initial begin
        logic [15:0] s1, s2, s_ref;
        logic [7:0]  m;
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        uo_out = '0; uio_out = '0; uio_oe = '0;
        win_len = W'(5); trig_mask = '0; trig_val = '0;
        repeat (3) tick;
        check_outs("rst", 1'b0, 1'b0, 16'hFFFF, 0);
        start = 1'b0; abort = 1'b0; rst = 1'b0;

        do_run(16'd1, 8'h00, 8'h00, 0, 3, 1'b0, s1);
        check_eq("efdf", 32'(s1), 32'h0000EFDF);
        do_run(16'd0, 8'h5A, 8'h11, 0, 0, 1'b0, s1);
        do_run(16'd4, 8'h80, 8'h80, 10, 0, 1'b0, s1);

        do_run(16'd6, 8'h0F, 8'h05, 2, 1, 1'b0, s1);
        do_run(16'd6, 8'h0F, 8'h05, 2, 2, 1'b0, s2);
        check_eq("oe_mask", 32'(s1), 32'(s2));

        do_run(16'd5, 8'h00, 8'h00, 0, 0, 1'b1, s1);

        win_len = W'(8); trig_mask = 8'h00; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        abort = 1'b1; start = 1'b1; win_len = W'(3);
        tick;
        abort = 1'b0; start = 1'b0;
        check_outs("abort", 1'b0, 1'b0, 16'hFFFF, 0);
        tick;
        check_outs("abort_idle", 1'b0, 1'b0, 16'hFFFF, 0);

        do_run(16'd7, 8'h00, 8'h00, 0, 2, 1'b0, s_ref);
        win_len = W'(7); trig_mask = 8'h00; start = 1'b1;
        uo_out = 8'h3C; uio_out = 8'hC3; uio_oe = 8'hFF;
        tick;
        start = 1'b0;
        repeat (3) tick;
        rst = 1'b1;
        tick;
        check_outs("rst_mid", 1'b0, 1'b0, 16'hFFFF, 0);
        rst = 1'b0;
        do_run(16'd7, 8'h00, 8'h00, 0, 2, 1'b0, s2);
        check_eq("rst_rerun", 32'(s2), 32'(s_ref));

        for (int r = 0; r < 20; r++) begin
            m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            do_run(16'($urandom_range(0, 12)), m, 8'($urandom),
                   (m == 8'h00) ? 0 : int'($urandom_range(0, 5)), 0, 1'b0, s1);
        end

        do_run(16'hFFFF, 8'h00, 8'h00, 0, 0, 1'b0, s1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/heichips25_sig_capture.md
HEICHIPS25_SIG_CAPTURE -- requirements
Module: heichips25_sig_capture

Interface
REQ-001 Parameter: WIN_W, default 16, width of the window-length input and of the sample counter.
REQ-002 Parameter: SEED, default 16'hFFFF, value loaded into the signature register at reset, start and abort.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: uo_out  input  8  dedicated outputs of the tiny wrapper.
REQ-006 Port: uio_out  input  8  bidirectional output values of the tiny wrapper.
REQ-007 Port: uio_oe  input  8  bidirectional output enables of the tiny wrapper.
REQ-008 Port: start  input  1  single-cycle request to arm a capture run.
REQ-009 Port: abort  input  1  cancels any run and returns to IDLE.
REQ-010 Port: win_len  input  WIN_W  number of samples per run; latched on an accepted start.
REQ-011 Port: trig_mask  input  8  uo_out bits that take part in the trigger compare; latched on an accepted start.
REQ-012 Port: trig_val  input  8  trigger compare value; latched on an accepted start.
REQ-013 Port: busy  output  1  high in ARM and CAPTURE.
REQ-014 Port: done  output  1  high in DONE.
REQ-015 Port: signature  output  16  MISR contents.
REQ-016 Port: sample_cnt  output  WIN_W  number of samples folded into the MISR in the current or last run.

Function
REQ-017 The FSM SHALL have the states IDLE, ARM, CAPTURE and DONE.
REQ-018 Sample word per cycle: d = {uio_out & uio_oe, uo_out}, with uio data in bits 15:8.
REQ-019 MISR step: s' = ((s<<1) XOR (s[15] ? 16'h1021 : 0)) XOR d, truncated to 16 bits.
REQ-020 Start acceptance:
- start is accepted only in IDLE or DONE; it is ignored in ARM and CAPTURE.
- On acceptance: win_len, trig_mask and trig_val are latched; signature = SEED; sample_cnt = 0; done = 0.
- Next state is ARM, or DONE if the latched win_len is 0.
REQ-021 Trigger and first sample in ARM:
- Match condition: (uo_out & mask) == (val & mask), using the latched mask and value; mask 0 matches immediately.
- On a match, that same cycle's d is folded as the first sample and sample_cnt becomes 1.
- Next state is CAPTURE, or DONE if win_len == 1.
- Without a match the FSM stays in ARM indefinitely.
REQ-022 CAPTURE: every cycle folds d and increments sample_cnt; when sample_cnt reaches win_len the FSM enters DONE on the following edge with no extra sample.
REQ-023 DONE: signature and sample_cnt hold until the next accepted start or an abort.
REQ-024 abort in any state: next state is IDLE; signature = SEED; sample_cnt = 0; done = 0.
REQ-025 abort and start in the same cycle: abort takes priority and start is dropped.
REQ-026 Latency: an accepted start at edge t gives busy = 1 after edge t; done rises exactly win_len edges after the trigger-match edge.
REQ-027 sample_cnt SHALL never exceed win_len and SHALL never wrap.
REQ-028 win_len = 2^WIN_W - 1 SHALL complete without overflow.
REQ-029 busy, done, signature and sample_cnt SHALL be registered outputs.

Reset
REQ-030 While rst = 1, on each clk edge: state = IDLE; busy = 0; done = 0; signature = SEED; sample_cnt = 0; latched mask, value and length = 0.
REQ-031 Reset SHALL override start and abort, and SHALL take effect mid-run with no partial result retained.
REQ-032 The first start SHALL be accepted on the first edge after rst falls.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Zero data, mask 0, win_len 1, start -> done after 2 edges; signature 16'hEFDF; sample_cnt 1.
- win_len 0, start -> DONE on the next edge; busy never 1; signature 16'hFFFF; sample_cnt 0.
- mask 8'h80, val 8'h80, uo_out bit 7 held 0 for 10 cycles then set; win_len 4 -> busy for 10 cycles in ARM; done 4 edges after the match; sample_cnt 4.
- uio_oe = 0 with uio_out toggling -> signature equals the run with uio_out = 0 (masking check).
- start during CAPTURE -> ignored, run completes unchanged; abort and start in the same cycle -> IDLE, signature 16'hFFFF.
- rst asserted mid-CAPTURE -> all outputs at reset values next edge; a new start afterwards gives a result identical to a fresh run.
